// File: rtl/sprite_bitmap_store.sv
// Double-banked sprite bitmap store.
// The renderer reads the displayed bank through a 1-cycle synchronous read port.
// The load stream fills the hidden bank, and the banks swap only on a frame pulse.
//
// state   | meaning
// IDLE    | no load in progress, stream stalled
// LOAD    | accepting pixels into the hidden bank
// PENDING | hidden bank complete, waiting for frame to swap
module sprite_bitmap_store #(
  parameter int SPR_WIDTH  = 8,
  parameter int SPR_HEIGHT = 8,
  parameter int SPR_DATAW  = 3,
  localparam int SPR_ROM_DEPTH = SPR_WIDTH * SPR_HEIGHT,
  localparam int AW = (SPR_ROM_DEPTH > 1) ? $clog2(SPR_ROM_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame,
  input  logic [AW-1:0]        spr_rom_addr,
  output logic [SPR_DATAW-1:0] spr_rom_data,
  input  logic                 load_start,
  input  logic                 wr_valid,
  input  logic [SPR_DATAW-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 load_busy,
  output logic                 load_done,
  output logic                 bank
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(SPR_ROM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(SPR_ROM_DEPTH - 1);

  logic [SPR_DATAW-1:0] mem_q [2][SPR_ROM_DEPTH];
  state_t               state_q;
  logic [AW-1:0]        wr_addr_q;
  logic                 bank_q;
  logic                 load_done_q;
  logic [SPR_DATAW-1:0] rd_data_q;
  logic [SPR_DATAW-1:0] rd_data_d;
  logic                 wr_fire;

  assign wr_ready  = (state_q == LOAD);
  assign load_busy = (state_q == LOAD) || (state_q == PENDING);
  assign wr_fire   = wr_valid && wr_ready && !rst;

  assign spr_rom_data = rd_data_q;
  assign load_done    = load_done_q;
  assign bank         = bank_q;

  // Read mux: addresses beyond the bitmap (non-power-of-two sizes) read as zero.
  always_comb begin
    rd_data_d = '0;
    if ({1'b0, spr_rom_addr} < DEPTH_W) begin
      rd_data_d = mem_q[bank_q][spr_rom_addr];
    end
  end

  // Registered read data, one cycle behind the address like a block ROM.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  // Pixel writes always land in the hidden bank; storage itself is never cleared.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[~bank_q][wr_addr_q] <= wr_data;
    end
  end

  // Load sequencer: write address, bank select and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      bank_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q   <= LOAD;
            wr_addr_q <= '0;
          end
        end
        LOAD: begin
          // A restart overrides the counter even if a beat lands this cycle.
          if (load_start) begin
            wr_addr_q <= '0;
          end else if (wr_fire) begin
            if (wr_addr_q == LAST_ADDR) begin
              state_q <= PENDING;
            end else begin
              wr_addr_q <= wr_addr_q + 1'b1;
            end
          end
        end
        PENDING: begin
          // The swap takes precedence over a restart arriving in the same cycle.
          if (frame) begin
            bank_q      <= ~bank_q;
            load_done_q <= 1'b1;
            state_q     <= IDLE;
          end else if (load_start) begin
            state_q   <= LOAD;
            wr_addr_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_bitmap_store.sv
// Self-checking bench for sprite_bitmap_store: an 8x8 instance and a 6x5 instance.
module tb_sprite_bitmap_store;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, frame, load_start, wr_valid;
  logic [5:0] spr_rom_addr;
  logic [2:0] wr_data, spr_rom_data;
  logic       wr_ready, load_busy, load_done, bank;

  logic       frame_n, load_start_n, wr_valid_n;
  logic [4:0] addr_n;
  logic [2:0] wr_data_n, data_n;
  logic       wr_ready_n, load_busy_n, load_done_n, bank_n;

  sprite_bitmap_store #(.SPR_WIDTH(8), .SPR_HEIGHT(8), .SPR_DATAW(3)) dut (
    .clk(clk), .rst(rst), .frame(frame), .spr_rom_addr(spr_rom_addr),
    .spr_rom_data(spr_rom_data), .load_start(load_start), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .load_busy(load_busy),
    .load_done(load_done), .bank(bank)
  );

  sprite_bitmap_store #(.SPR_WIDTH(6), .SPR_HEIGHT(5), .SPR_DATAW(3)) dut_n (
    .clk(clk), .rst(rst), .frame(frame_n), .spr_rom_addr(addr_n),
    .spr_rom_data(data_n), .load_start(load_start_n), .wr_valid(wr_valid_n),
    .wr_data(wr_data_n), .wr_ready(wr_ready_n), .load_busy(load_busy_n),
    .load_done(load_done_n), .bank(bank_n)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference contents, written from the stimulus as beats are sent.
  logic [2:0] ref_mem   [2][64];
  logic [2:0] ref_mem_n [2][30];
  logic       ref_bank, ref_bank_n;
  logic [2:0] sb_q[$];
  logic [2:0] sb_n_q[$];
  bit         rd_en, rd_en_n;

  // One clock: queue the read expectation for this cycle, clock, compare what came out.
  task automatic tick();
    if (rd_en) sb_q.push_back(ref_mem[ref_bank][spr_rom_addr]);
    if (rd_en_n) sb_n_q.push_back((addr_n < 5'd30) ? ref_mem_n[ref_bank_n][addr_n] : 3'd0);
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) check("rd", 32'(spr_rom_data), 32'(sb_q.pop_front()));
    if (sb_n_q.size() != 0) check("rd_np2", 32'(data_n), 32'(sb_n_q.pop_front()));
  endtask

  // Send n accepted beats to the 8x8 instance. val<0 means pixel = index%8.
  task automatic load_beats(input int n, input int val, input bit gaps, input bit last_frame);
    int cnt = 0;
    int t = 0;
    logic [2:0] d;
    while (cnt < n) begin
      wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = (val < 0) ? 3'(cnt % 8) : 3'(val);
      wr_data = d;
      if (wr_valid) begin
        check("wr_ready_load", 32'(wr_ready), 32'd1);
        ref_mem[~ref_bank][cnt] = d;
        if (last_frame && cnt == n - 1) frame = 1'b1;
        cnt++;
      end
      if (rd_en) spr_rom_addr = 6'(t % 64);
      t++;
      tick();
    end
    wr_valid = 1'b0;
    frame    = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b1; wr_valid = 1'b1; frame = 1'b0;
    spr_rom_addr = '0; wr_data = '0;
    frame_n = 1'b0; load_start_n = 1'b0; wr_valid_n = 1'b0; addr_n = '0; wr_data_n = '0;
    rd_en = 1'b0; rd_en_n = 1'b0; ref_bank = 1'b0; ref_bank_n = 1'b0;

    // Reset with load_start/wr_valid held high
    tick();
    tick();
    check("rst_bank", 32'(bank), 32'd0);
    check("rst_data", 32'(spr_rom_data), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd0);
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_bank_np2", 32'(bank_n), 32'd0);
    rst = 1'b0; load_start = 1'b0; wr_valid = 1'b0;
    tick();
    check("idle_busy", 32'(load_busy), 32'd0);

    // Full load of index%8 with random gaps, then swap
    start_load();
    check("load_busy", 32'(load_busy), 32'd1);
    load_beats(64, -1, 1'b1, 1'b0);
    check("pend_ready", 32'(wr_ready), 32'd0);
    check("pend_busy", 32'(load_busy), 32'd1);
    check("pend_bank", 32'(bank), 32'd0);
    pulse_frame();
    ref_bank = ~ref_bank;
    check("swap_bank", 32'(bank), 32'd1);
    check("swap_done", 32'(load_done), 32'd1);
    tick();
    check("done_once", 32'(load_done), 32'd0);
    check("idle_after_swap", 32'(load_busy), 32'd0);
    spr_rom_addr = 6'd13; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("addr13", 32'(spr_rom_data), 32'd5);

    // Frame in IDLE does nothing
    pulse_frame();
    check("idle_frame_bank", 32'(bank), 32'd1);
    check("idle_frame_done", 32'(load_done), 32'd0);

    // Double buffering: bank 0 all 7s, read sweep during the next load
    start_load();
    load_beats(64, 7, 1'b0, 1'b0);
    pulse_frame();
    ref_bank = ~ref_bank;
    check("bank0_shown", 32'(bank), 32'd0);
    start_load();
    rd_en = 1'b1;
    load_beats(64, 3, 1'b0, 1'b0);
    rd_en = 1'b0;
    pulse_frame();
    ref_bank = ~ref_bank;
    spr_rom_addr = 6'd40; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("new_bank_data", 32'(spr_rom_data), 32'd3);

    // Restart mid-load
    start_load();
    load_beats(20, 1, 1'b1, 1'b0);
    start_load();
    load_beats(64, 2, 1'b1, 1'b0);
    check("restart_pend", 32'(load_busy), 32'd1);
    pulse_frame();
    ref_bank = ~ref_bank;
    check("restart_bank", 32'(bank), 32'd0);
    rd_en = 1'b1;
    for (int a = 0; a < 64; a++) begin
      spr_rom_addr = 6'(a);
      tick();
    end
    rd_en = 1'b0;
    tick();
    check("restart_last", 32'(spr_rom_data), 32'd2);

    // Last beat together with frame: no swap until the next frame
    start_load();
    load_beats(64, 4, 1'b0, 1'b1);
    check("lastbeat_frame_bank", 32'(bank), 32'd0);
    check("lastbeat_frame_busy", 32'(load_busy), 32'd1);
    check("lastbeat_frame_done", 32'(load_done), 32'd0);
    repeat (9) tick();
    check("still_pending", 32'(wr_ready), 32'd0);
    pulse_frame();
    ref_bank = ~ref_bank;
    check("late_swap_bank", 32'(bank), 32'd1);
    check("late_swap_done", 32'(load_done), 32'd1);

    // load_start together with frame in PENDING: swap wins
    start_load();
    load_beats(64, 5, 1'b0, 1'b0);
    frame = 1'b1; load_start = 1'b1;
    tick();
    frame = 1'b0; load_start = 1'b0;
    ref_bank = ~ref_bank;
    check("both_bank", 32'(bank), 32'd0);
    check("both_done", 32'(load_done), 32'd1);
    check("both_busy", 32'(load_busy), 32'd0);
    check("both_ready", 32'(wr_ready), 32'd0);
    spr_rom_addr = 6'd9; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("both_idle", 32'(load_busy), 32'd0);

    // Non-power-of-two instance, 6x5
    load_start_n = 1'b1;
    tick();
    load_start_n = 1'b0;
    for (int i = 0; i < 30; i++) begin
      wr_valid_n = 1'b1;
      wr_data_n  = 3'((i * 3) % 8);
      ref_mem_n[~ref_bank_n][i] = wr_data_n;
      check("np2_ready", 32'(wr_ready_n), 32'd1);
      tick();
    end
    wr_valid_n = 1'b0;
    check("np2_pend_busy", 32'(load_busy_n), 32'd1);
    check("np2_pend_ready", 32'(wr_ready_n), 32'd0);
    frame_n = 1'b1;
    tick();
    frame_n = 1'b0;
    ref_bank_n = ~ref_bank_n;
    check("np2_bank", 32'(bank_n), 32'd1);
    check("np2_done", 32'(load_done_n), 32'd1);
    rd_en_n = 1'b1;
    addr_n = 5'd29;
    tick();
    addr_n = 5'd31;
    tick();
    rd_en_n = 1'b0;
    check("np2_addr31", 32'(data_n), 32'd0);

    // Reset mid-load abandons the load and returns to bank 0
    load_start_n = 1'b1;
    tick();
    load_start_n = 1'b0;
    wr_valid_n = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; wr_valid_n = 1'b0;
    check("midrst_bank", 32'(bank_n), 32'd0);
    check("midrst_busy", 32'(load_busy_n), 32'd0);
    check("midrst_ready", 32'(wr_ready_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_bitmap_store.md
# sprite_bitmap_store

Double-banked sprite bitmap memory that serves the synchronous-ROM read port of a sprite renderer and accepts new bitmap data through a valid/ready pixel stream. The renderer side drives `spr_rom_addr` and receives `spr_rom_data` one cycle later. The load side writes a complete bitmap into the inactive bank while the active bank is being displayed. Completed loads swap banks only on a frame-start pulse, so a sprite never tears mid-frame.

## Interface

Parameters:
- `SPR_WIDTH`, default 8: sprite bitmap width in pixels.
- `SPR_HEIGHT`, default 8: sprite bitmap height in pixels.
- `SPR_DATAW`, default 3: bits per pixel.
- `SPR_ROM_DEPTH` (localparam): `SPR_WIDTH*SPR_HEIGHT`, the number of words per bank.

Ports:
- `clk` (in, 1): the single clock.
- `rst` (in, 1): reset; synchronous, active-high.
- `frame` (in, 1): one-cycle pulse at the start of a frame; the swap point.
- `spr_rom_addr` (in, `$clog2(SPR_ROM_DEPTH)`): read address from the renderer.
- `spr_rom_data` (out, `SPR_DATAW`): registered read data.
- `load_start` (in, 1): one-cycle pulse that begins or restarts a bitmap load.
- `wr_valid` (in, 1): write-stream pixel valid.
- `wr_data` (in, `SPR_DATAW`): write-stream pixel, in row-major order.
- `wr_ready` (out, 1): the block accepts a pixel this cycle.
- `load_busy` (out, 1): high in LOAD or PENDING.
- `load_done` (out, 1): one-cycle pulse in the cycle after the bank swap.
- `bank` (out, 1): index of the bank currently served to the reader.

## Operation

Storage:
- Two banks of `SPR_ROM_DEPTH` words, each `SPR_DATAW` bits wide.
- Contents are not reset.

Read port:
- `spr_rom_data <= mem[bank][spr_rom_addr]` on every clock; there is no enable.
- If `spr_rom_addr >= SPR_ROM_DEPTH` (non-power-of-two sizes), the registered data is 0.

Write address:
- `wr_addr` is an internal counter, `$clog2(SPR_ROM_DEPTH)` bits wide.
- Writes always target bank `~bank`.
- An accepted beat is `wr_valid && wr_ready`. It writes `mem[~bank][wr_addr] <= wr_data`.

State machine (IDLE, LOAD, PENDING):
- IDLE:
  - `wr_ready=0`.
  - `load_start` → LOAD, `wr_addr<=0`.
  - `wr_valid` is ignored.
- LOAD:
  - `wr_ready=1`.
  - An accepted beat with `wr_addr != SPR_ROM_DEPTH-1` increments `wr_addr`.
  - An accepted beat with `wr_addr == SPR_ROM_DEPTH-1` goes to PENDING; `wr_addr` holds.
  - `load_start` restarts the load: `wr_addr<=0`. Any beat accepted in the same cycle is written at the old address, and then the counter is overridden to 0.
- PENDING:
  - `wr_ready=0`.
  - `frame` → `bank <= ~bank`, `load_done<=1` for the next cycle, then IDLE.
  - `load_start` without `frame` → LOAD with `wr_addr<=0`, overwriting the pending bitmap. No swap occurs.
  - `load_start` and `frame` in the same cycle: the swap wins, the state goes to IDLE, and `load_start` is dropped.
- In IDLE or LOAD, `frame` has no effect.

Simultaneous events:
- Last beat and `frame` in the same cycle: the beat is written and the state goes to PENDING. The swap waits for the next `frame`.

Outputs:
- `wr_ready` is a combinational decode of the state (LOAD only). It has no dependency on `wr_valid`.
- `load_busy` is a combinational decode of the state.
- `bank` and `load_done` are registered.

## Timing

- Read latency is 1 cycle. An address presented at edge N gives data valid after edge N+1; this matches a synchronous block ROM.
- Bank swap:
  - The read sampled on the edge where `frame` is seen uses the old bank.
  - Reads sampled on later edges use the new bank.
  - `load_done` is high for exactly the cycle after that edge.
- A full load takes a minimum of `SPR_ROM_DEPTH` accepted beats. `wr_valid` gaps are allowed at any point.
- Write/read hazard: none. Writes never touch bank `bank`.
- Reset values:
  - State IDLE, `wr_addr=0`.
  - `bank=0`, `spr_rom_data=0`, `load_done=0`, `wr_ready=0`, `load_busy=0`.
- `rst` mid-load abandons the load: the state goes to IDLE and `bank` goes to 0. The partially written bank contents are undefined for verification.
- `rst` has priority over every other input in the same cycle.

## Test plan

- Reset: assert `rst` for 2 cycles with `wr_valid=1` and `load_start=1`.
  - Required: `bank=0`, `spr_rom_data=0`, `wr_ready=0`, `load_busy=0`, `load_done=0`.
- Full load and swap (8x8, 3bpp):
  - Stimulus: `load_start`, then 64 beats with `wr_data=i%8`, with random `wr_valid` gaps; then `frame`.
  - Required: PENDING with `wr_ready=0` after beat 63. `bank` goes 0→1 on `frame`. `load_done` pulses once. Address 13 then returns 5 on the next cycle.
- Double buffering:
  - Stimulus: bank 0 holds all 7s; during a second load into bank 1, sweep addresses 0..63.
  - Required: every read returns 7 one cycle later, until the `frame` swap.
- Restart:
  - Stimulus: `load_start`, 20 beats of 1, `load_start` again, then 64 beats of 2, then `frame`.
  - Required: all 64 addresses read 2.
- Simultaneous events:
  - Stimulus: last beat in the same cycle as `frame`.
  - Required: no swap. A second `frame` 10 cycles later swaps. `load_start` arriving with `frame` in PENDING swaps and is otherwise ignored.
- Non-power-of-two (`SPR_WIDTH=6`, `SPR_HEIGHT=5`):
  - Stimulus: load 30 beats, then `frame`.
  - Required: PENDING after beat 29, swap on `frame`. Address 31 returns 0.
